// File: rtl/mod_mul_1039_if.sv
// Operand/result handshake bundle for the GF(1039) sequential multiplier.
// The master drives operands and result acceptance; the slave is the multiplier.
interface mod_mul_1039_if #(
    parameter int W = 11
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         out_err;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, out_err, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, out_err, busy
    );
endinterface

// File: rtl/mod_mul_1039_seq.sv
// Sequential (a*b) mod 1039: 11-cycle shift-add product, then Barrett
// quotient estimate, subtract and single-cycle double correction.
module mod_mul_1039_seq #(
    parameter int P  = 1039,
    parameter int W  = 11,
    parameter int MU = 4036
) (
    input  logic              clk,
    input  logic              rst_n,
    mod_mul_1039_if.slave     bus
);
    localparam int AW = 2 * W - 1;
    localparam int RW = 2 * W;
    localparam int QW = 3 * W + 1;
    localparam int CW = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_QEST = 3'd2,
        ST_SUB  = 3'd3,
        ST_CORR = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [AW-1:0]   acc_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    q_r;
    logic [RW-1:0]   r_r;
    logic [W-1:0]    result_r;
    logic            err_r;
    logic            out_valid_r;
    logic            in_ready_r;
    logic            busy_r;

    logic            accept_s;
    logic            range_bad_s;
    logic [AW-1:0]   addend_s;
    logic [W-1:0]    q_est_s;
    logic [RW-1:0]   r_diff_s;
    logic [W-1:0]    corr_s;

    // Handshake qualification and operand range check.
    always_comb begin
        accept_s    = bus.in_valid && in_ready_r;
        range_bad_s = (bus.a >= W'(P)) || (bus.b >= W'(P));
    end

    // Shift-add partial product, Barrett estimate/subtract and final correction.
    always_comb begin
        if (b_r[cnt_r]) begin
            addend_s = AW'(a_r) << cnt_r;
        end else begin
            addend_s = '0;
        end
        // q fits W bits because acc never exceeds (P-1)^2.
        q_est_s  = W'((QW'(acc_r) * QW'(MU)) >> (2 * W));
        r_diff_s = RW'(acc_r) - (RW'(q_r) * RW'(P));
        if (r_r >= RW'(2 * P)) begin
            corr_s = W'(r_r - RW'(2 * P));
        end else if (r_r >= RW'(P)) begin
            corr_s = W'(r_r - RW'(P));
        end else begin
            corr_s = W'(r_r);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = range_bad_s ? ST_DONE : ST_MUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CW'(W - 1)) begin
                    state_s = ST_QEST;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_QEST: state_s = ST_SUB;
            ST_SUB:  state_s = ST_CORR;
            ST_CORR: state_s = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == ST_DONE);
            in_ready_r  <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Datapath registers; result and error are held untouched while in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            q_r      <= '0;
            r_r      <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        acc_r <= '0;
                        cnt_r <= '0;
                        if (range_bad_s) begin
                            result_r <= '0;
                            err_r    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_r + addend_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                ST_QEST: q_r <= q_est_s;
                ST_SUB:  r_r <= r_diff_s;
                ST_CORR: begin
                    result_r <= corr_s;
                    err_r    <= 1'b0;
                end
                ST_DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    acc_r <= '0;
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.out_err   = err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mod_mul_1039_seq.sv
// Directed table plus multi-cycle corner sequences for the GF(1039) multiplier.
module tb_mod_mul_1039_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    mod_mul_1039_if #(.W(11)) bus ();

    mod_mul_1039_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int res;
        int err;
    } vec_t;

    vec_t tbl[13];
    int   bset[5];

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input int av, input int bv, input int er, input int ee,
                          input int hold, input string tag);
        int lat;
        int res0;
        @(negedge clk);
        chk({tag, " in_ready before"}, int'(bus.in_ready), 1);
        bus.a         = 11'(av);
        bus.b         = 11'(bv);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 11'($urandom);
        bus.b        = 11'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        chk({tag, " out_valid"}, int'(bus.out_valid), 1);
        if (ee == 1) begin
            chk({tag, " err latency<=1"}, int'(lat <= 1), 1);
        end else begin
            chk({tag, " latency"}, lat, 14);
        end
        chk({tag, " result"}, int'(bus.result), er);
        chk({tag, " out_err"}, int'(bus.out_err), ee);
        chk({tag, " result<P"}, int'(bus.result < 11'd1039), 1);
        res0 = int'(bus.result);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, int'(bus.out_valid), 1);
            chk({tag, " hold result"}, int'(bus.result), res0);
            chk({tag, " hold err"}, int'(bus.out_err), ee);
            chk({tag, " hold in_ready"}, int'(bus.in_ready), 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " valid drop"}, int'(bus.out_valid), 0);
        chk({tag, " in_ready rise"}, int'(bus.in_ready), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, int'(bus.in_ready), 1);
        chk({tag, " out_valid"}, int'(bus.out_valid), 0);
        chk({tag, " result"}, int'(bus.result), 0);
        chk({tag, " out_err"}, int'(bus.out_err), 0);
        chk({tag, " busy"}, int'(bus.busy), 0);
    endtask

    // Start an op, then pulse reset after edges_in rising edges past the accept.
    task automatic reset_mid(input int av, input int bv, input int edges_in, input string tag);
        @(negedge clk);
        bus.a        = 11'(av);
        bus.b        = 11'(bv);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (edges_in) @(posedge clk);
        #1;
        chk({tag, " busy before"}, int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk_reset_vals(tag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " no spurious valid"}, int'(bus.out_valid), 0);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_miss        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 11'd0;
        bus.b         = 11'd0;
        bus.out_ready = 1'b0;

        tbl[0]  = '{a: 1000, b: 1000, res: 482,  err: 0};
        tbl[1]  = '{a: 1038, b: 1038, res: 1,    err: 0};
        tbl[2]  = '{a: 2,    b: 519,  res: 1038, err: 0};
        tbl[3]  = '{a: 0,    b: 777,  res: 0,    err: 0};
        tbl[4]  = '{a: 1039, b: 5,    res: 0,    err: 1};
        tbl[5]  = '{a: 3,    b: 2047, res: 0,    err: 1};
        tbl[6]  = '{a: 7,    b: 149,  res: 4,    err: 0};
        tbl[7]  = '{a: 1,    b: 1038, res: 1038, err: 0};
        tbl[8]  = '{a: 1038, b: 517,  res: 522,  err: 0};
        tbl[9]  = '{a: 123,  b: 456,  res: 1021, err: 0};
        tbl[10] = '{a: 1038, b: 2,    res: 1037, err: 0};
        tbl[11] = '{a: 520,  b: 520,  res: 260,  err: 0};
        tbl[12] = '{a: 1038, b: 1039, res: 0,    err: 1};
        bset    = '{0, 1, 2, 517, 1038};

        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].err, i % 3, $sformatf("tbl%0d", i));
        end

        run_op(1000, 1000, 482, 0, 20, "hold20");

        run_op(1039, 5, 0, 1, 0, "pre_rst_err");
        reset_mid(1000, 1000, 5, "rst_mul");
        run_op(7, 149, 4, 0, 0, "post_rst_mul");
        reset_mid(1000, 1000, 12, "rst_sub");
        run_op(7, 149, 4, 0, 0, "post_rst_sub");

        for (int av = 0; av <= 1038; av += 13) begin
            for (int j = 0; j < 5; j++) begin
                run_op(av, bset[j], (av * bset[j]) % 1039, 0, int'($urandom_range(0, 3)),
                       $sformatf("sweep a=%0d b=%0d", av, bset[j]));
            end
        end
        for (int j = 0; j < 5; j++) begin
            run_op(1038, bset[j], (1038 * bset[j]) % 1039, 0, int'($urandom_range(0, 3)),
                   $sformatf("sweep a=1038 b=%0d", bset[j]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
